// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Purpose  : Shared types and constants for the programmable clock divider
//            controller (clk_div_ctrl) and its counter core (clk_div_core).
// Contents : state_e    - controller state encoding (STOP / RUN / DRAIN)
//            MIN_DIV    - smallest legal divide ratio
//            DEFAULT_DIV_C - ratio in effect after reset
//            CNT_W_DEF  - default counter / ratio width
// Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int CNT_W_DEF     = 8;
    localparam int MIN_DIV       = 2;
    localparam int DEFAULT_DIV_C = 9;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_core
// Purpose  : Period counter and registered clk_out / tick generation.
// Ports    : clk, rst          - system clock, async active-high reset
//            cnt_en_i          - advance the counter this cycle
//            clr_i             - force counter and outputs to idle next cycle
//            div_cur_i         - ratio of the period currently being counted
//            div_nxt_i         - ratio in effect from the next cycle on
//            last_o            - counter is on the last cycle of the period
//            clk_out_o, tick_o - registered divided clock and period tick
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] div_cur_i,
    input  logic [CNT_W-1:0] div_nxt_i,
    output logic             last_o,
    output logic             clk_out_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clk_out_q;
    logic             clk_out_d;
    logic             tick_q;
    logic             tick_d;
    logic             w_last;

    assign w_last = (cnt_q == (div_cur_i - c_ONE));

    // The outputs are decoded from the next-state count and the next-state
    // ratio, so a ratio change at a boundary already shapes the first cycle
    // of the new period and the pins stay glitch-free flops.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i) begin
            cnt_d = w_last ? '0 : (cnt_q + c_ONE);
        end
        clk_out_d = !clr_i && (cnt_d < (div_nxt_i >> 1));
        tick_d    = !clr_i && (cnt_d == (div_nxt_i - c_ONE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign last_o    = w_last;
    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;

endmodule : clk_div_core
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl
// Purpose  : Programmable synchronous clock divider with glitch-free ratio
//            updates at period boundaries and graceful start/stop.
// Ports    : clk, rst     - system clock, async active-high reset
//            en_i         - run request; 0 stops at the end of the period
//            div_val_i    - requested ratio, sampled on div_load_i
//            div_load_i   - one-cycle load strobe
//            div_pend_o   - a validated ratio waits to be applied
//            div_err_o    - one-cycle pulse: load rejected (ratio < 2)
//            div_cur_o    - ratio currently in effect
//            clk_out_o    - registered divided clock
//            tick_o       - registered pulse on the last cycle of a period
//            running_o    - high in RUN and DRAIN
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_val_i,
    input  logic             div_load_i,
    output logic             div_pend_o,
    output logic             div_err_o,
    output logic [CNT_W-1:0] div_cur_o,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             running_o
);

    localparam logic [CNT_W-1:0] c_DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_MIN_DIV = CNT_W'(MIN_DIV);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] div_cur_q;
    logic [CNT_W-1:0] div_cur_d;
    logic [CNT_W-1:0] pend_val_q;
    logic [CNT_W-1:0] pend_val_d;
    logic             div_pend_q;
    logic             div_pend_d;
    logic             div_err_q;
    logic             div_err_d;
    logic             running_q;
    logic             running_d;

    logic             w_core_last;
    logic             w_bound;
    logic             w_apply;
    logic             w_load_ok;
    logic             w_cnt_en;
    logic             w_clr;

    // A boundary only exists while counting; in STOP the counter idles at 0.
    assign w_bound   = (state_q != ST_STOP) && w_core_last;
    assign w_load_ok = div_load_i && (div_val_i >= c_MIN_DIV);
    // In STOP nothing is being shaped, so a pending ratio applies at once.
    assign w_apply   = div_pend_q && ((state_q == ST_STOP) || w_bound);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOP:  state_d = en_i ? ST_RUN : ST_STOP;
            ST_RUN:   state_d = en_i ? ST_RUN : ST_DRAIN;
            ST_DRAIN: begin
                if (en_i) begin
                    state_d = ST_RUN;
                end else if (w_bound) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default:  state_d = ST_STOP;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        w_cnt_en  = (state_q != ST_STOP);
        w_clr     = (state_d == ST_STOP);
        running_d = (state_d != ST_STOP);
    end

    // ---------------- load / pending ratio ----------------
    // The boundary consumes the previously registered pending value; a load
    // landing on the same cycle becomes the next pending value.
    always_comb begin
        div_cur_d  = w_apply ? pend_val_q : div_cur_q;
        pend_val_d = w_load_ok ? div_val_i : pend_val_q;
        div_err_d  = div_load_i && !w_load_ok;
        if (w_load_ok) begin
            div_pend_d = 1'b1;
        end else if (w_apply) begin
            div_pend_d = 1'b0;
        end else begin
            div_pend_d = div_pend_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cur_q  <= c_DEF_DIV;
            pend_val_q <= '0;
            div_pend_q <= 1'b0;
            div_err_q  <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            div_cur_q  <= div_cur_d;
            pend_val_q <= pend_val_d;
            div_pend_q <= div_pend_d;
            div_err_q  <= div_err_d;
            running_q  <= running_d;
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .cnt_en_i  (w_cnt_en),
        .clr_i     (w_clr),
        .div_cur_i (div_cur_q),
        .div_nxt_i (div_cur_d),
        .last_o    (w_core_last),
        .clk_out_o (clk_out_o),
        .tick_o    (tick_o)
    );

    assign div_pend_o = div_pend_q;
    assign div_err_o  = div_err_q;
    assign div_cur_o  = div_cur_q;
    assign running_o  = running_q;

endmodule : clk_div_ctrl
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_ctrl
// Purpose  : Self-checking bench for clk_div_ctrl (scoreboard of expected
//            per-cycle outputs plus fixed-pattern checks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] div_val = 8'd0;
    logic       div_load = 1'b0;

    wire        div_pend;
    wire        div_err;
    wire  [7:0] div_cur;
    wire        clk_out;
    wire        tick;
    wire        running;

    clk_div_ctrl #(.CNT_W(8), .DEFAULT_DIV(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .div_val_i  (div_val),
        .div_load_i (div_load),
        .div_pend_o (div_pend),
        .div_err_o  (div_err),
        .div_cur_o  (div_cur),
        .clk_out_o  (clk_out),
        .tick_o     (tick),
        .running_o  (running)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // {clk_out, tick, running, div_pend, div_err, div_cur}
    wire  [12:0] w_obs = {clk_out, tick, running, div_pend, div_err, div_cur};
    logic [12:0] sb[$];
    logic [12:0] e;

    // Reference model state: 0 = STOP, 1 = RUN, 2 = DRAIN
    int m_state = 0;
    int m_cnt   = 0;
    int m_div   = 9;
    int m_pv    = 0;
    bit m_pend  = 1'b0;

    task automatic m_reset();
        m_state = 0;
        m_cnt   = 0;
        m_div   = 9;
        m_pv    = 0;
        m_pend  = 1'b0;
    endtask

    // One clock: advance the model on the edge, push what the DUT must show.
    task automatic cyc();
        bit bnd, apply, err, o_clk, o_tick;
        int ns, nc, nd;
        @(posedge clk);
        if (rst) begin
            m_reset();
            sb.push_back({5'b00000, 8'd9});
        end else begin
            bnd   = (m_state != 0) && (m_cnt == m_div - 1);
            apply = m_pend && ((m_state == 0) || bnd);
            nd    = apply ? m_pv : m_div;
            err   = div_load && (div_val < 8'd2);
            if (div_load && div_val >= 8'd2) begin
                m_pv   = int'(div_val);
                m_pend = 1'b1;
            end else if (apply) begin
                m_pend = 1'b0;
            end
            case (m_state)
                0:       ns = en ? 1 : 0;
                1:       ns = en ? 1 : 2;
                default: ns = en ? 1 : (bnd ? 0 : 2);
            endcase
            nc      = (ns == 0 || m_state == 0 || bnd) ? 0 : m_cnt + 1;
            m_state = ns;
            m_cnt   = nc;
            m_div   = nd;
            o_clk   = (ns != 0) && (nc < nd / 2);
            o_tick  = (ns != 0) && (nc == nd - 1);
            sb.push_back({o_clk, o_tick, (ns != 0), m_pend, err, 8'(nd)});
        end
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (w_obs !== {5'b00000, 8'd9}) begin
            errors++;
            $display("FAIL reset_async: got %b required %b", w_obs, {5'b00000, 8'd9});
        end
        repeat (2) begin
            cyc();
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL reset_hold: got %b required %b", w_obs, e);
            end
        end
        #2 rst = 1'b0;
        repeat (10) begin
            cyc();
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL idle_en0: got %b required %b", w_obs, e);
            end
        end
        checks++;
        if (clk_out !== 1'b0 || running !== 1'b0 || div_cur !== 8'd9 || div_pend !== 1'b0) begin
            errors++;
            $display("FAIL idle_state: clk_out=%b running=%b div_cur=%0d div_pend=%b required 0 0 9 0",
                     clk_out, running, div_cur, div_pend);
        end
    endtask

    task automatic test_default_run();
        en = 1'b1;
        for (int k = 0; k < 36; k++) begin
            cyc();
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL default_run k=%0d: got %b required %b", k, w_obs, e);
            end
            // Fixed N=9 waveform: 4 high, 5 low, tick on the last low cycle.
            checks++;
            if (clk_out !== ((k % 9) < 4) || tick !== ((k % 9) == 8) || running !== 1'b1) begin
                errors++;
                $display("FAIL default_pattern k=%0d: clk_out=%b tick=%b running=%b required %b %b 1",
                         k, clk_out, tick, running, ((k % 9) < 4), ((k % 9) == 8));
            end
        end
    endtask

    task automatic test_load_ratio();
        int guard = 0;
        while (m_cnt != 2 && guard < 20) begin
            cyc();
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL load_wait: got %b required %b", w_obs, e);
            end
            guard++;
        end
        div_val  = 8'd4;
        div_load = 1'b1;
        cyc();
        div_load = 1'b0;
        e = sb.pop_front();
        checks++;
        if (w_obs !== e || div_pend !== 1'b1 || div_cur !== 8'd9) begin
            errors++;
            $display("FAIL load4_pending: got %b required %b (div_pend 1, div_cur 9)", w_obs, e);
        end
        repeat (20) begin
            cyc();
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL load4_run: got %b required %b", w_obs, e);
            end
        end
        checks++;
        if (div_cur !== 8'd4 || div_pend !== 1'b0) begin
            errors++;
            $display("FAIL load4_applied: div_cur=%0d div_pend=%b required 4 0", div_cur, div_pend);
        end
    endtask

    task automatic test_bad_load();
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            div_load = (i < 2);
            div_val  = (i == 0) ? 8'd1 : 8'd0;
            cyc();
            e = sb.pop_front();
            pulses += int'(div_err);
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL bad_load i=%0d: got %b required %b", i, w_obs, e);
            end
        end
        div_load = 1'b0;
        checks++;
        if (pulses != 2 || div_cur !== 8'd4 || div_pend !== 1'b0) begin
            errors++;
            $display("FAIL bad_load_summary: pulses=%0d div_cur=%0d div_pend=%b required 2 4 0",
                     pulses, div_cur, div_pend);
        end
    endtask

    task automatic test_drain();
        int guard = 0;
        int n = 0;
        div_val  = 8'd9;
        div_load = 1'b1;
        cyc();
        void'(sb.pop_front());
        div_load = 1'b0;
        while (!(m_div == 9 && m_state == 1 && m_cnt == 1) && guard < 40) begin
            cyc();
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL drain_prep: got %b required %b", w_obs, e);
            end
            guard++;
        end
        // High phase of an N=9 period: stop must complete the period.
        en = 1'b0;
        while (running === 1'b1 && n < 30) begin
            cyc();
            e = sb.pop_front();
            n++;
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL drain_stop n=%0d: got %b required %b", n, w_obs, e);
            end
        end
        checks++;
        if (n != 8 || clk_out !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL drain_stop_len: cycles=%0d clk_out=%b running=%b required 8 0 0",
                     n, clk_out, running);
        end
        // Restart, drop en, reassert inside DRAIN: output must be continuous.
        en = 1'b1;
        repeat (3) begin
            cyc();
            void'(sb.pop_front());
        end
        en = 1'b0;
        repeat (2) begin
            cyc();
            void'(sb.pop_front());
        end
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            e = sb.pop_front();
            checks++;
            if (w_obs !== e || running !== 1'b1) begin
                errors++;
                $display("FAIL drain_resume k=%0d: got %b required %b running=1", k, w_obs, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int guard = 0;
        div_load = 1'b1;
        div_val  = 8'd5;
        cyc();
        void'(sb.pop_front());
        div_val  = 8'd6;
        cyc();
        void'(sb.pop_front());
        div_load = 1'b0;
        while (m_pend && guard < 30) begin
            cyc();
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL b2b_wait: got %b required %b", w_obs, e);
            end
            guard++;
        end
        checks++;
        if (div_cur !== 8'd6 || div_pend !== 1'b0) begin
            errors++;
            $display("FAIL b2b_last_wins: div_cur=%0d div_pend=%b required 6 0", div_cur, div_pend);
        end
        // A new pending ratio is discarded by an asynchronous mid-cycle reset.
        div_load = 1'b1;
        div_val  = 8'd7;
        cyc();
        void'(sb.pop_front());
        div_load = 1'b0;
        cyc();
        void'(sb.pop_front());
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_reset();
        checks++;
        if (w_obs !== {5'b00000, 8'd9}) begin
            errors++;
            $display("FAIL reset_midrun: got %b required %b", w_obs, {5'b00000, 8'd9});
        end
        cyc();
        void'(sb.pop_front());
        #2 rst = 1'b0;
        repeat (4) begin
            cyc();
            e = sb.pop_front();
            checks++;
            if (w_obs !== e || div_cur !== 8'd9) begin
                errors++;
                $display("FAIL post_reset: got %b required %b", w_obs, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_load_ratio();
        test_bad_load();
        test_drain();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clk_div_ctrl
`default_nettype wire
